// File: rtl/bcd_seg_scan_pkg.sv
// Shared display definitions: active-low segment codes, digit-select idle value
// and the digit index type used by the scanner. Other display blocks import these.
package bcd_seg_scan_pkg;

  // Segment patterns, active-low, ordered {dp,g,f,e,d,c,b,a}; dp stays off.
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  // All digit enables released (active-low).
  localparam logic [2:0] SEL_OFF   = 3'b111;

  // Which digit the scanner is currently dwelling on. DIG_INVALID is never
  // entered in normal operation; the scanner recovers from it to units.
  typedef enum logic [1:0] {
    DIG_UNITS    = 2'd0,
    DIG_TENS     = 2'd1,
    DIG_HUNDREDS = 2'd2,
    DIG_INVALID  = 2'd3
  } digit_e;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-low 7-segment decoder with a blank override.
// Non-decimal nibbles show a dash rather than raising any error.
module bcd_to_seg
  import bcd_seg_scan_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);

  // Blank wins over the digit value; otherwise look the nibble up.
  always_comb begin
    seg_o = SEG_DASH;
    if (blank_i) begin
      seg_o = SEG_BLANK;
    end else begin
      case (nibble_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// Multiplexed common-anode 3-digit 7-segment scanner. A loaded BCD word sits in
// a shadow register and is only promoted to the displayed value when the scan
// wraps from hundreds back to units, so one scan never mixes two values.
module bcd_seg_scan
  import bcd_seg_scan_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W    = 16,
  parameter int BLANK_LZ = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [11:0] bcd_in,
  output logic [2:0]  sel,
  output logic [7:0]  seg
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  digit_e           idx_q, idx_d;
  logic [11:0]      shadow_q, shadow_d;
  logic [11:0]      active_q, active_d;
  logic [2:0]       sel_q, sel_d;
  logic [7:0]       seg_q, seg_d;
  logic             tick;
  logic             wrap;
  logic [3:0]       digitNibble;
  logic             digitBlank;

  assign tick = (cnt_q == CNT_W'(SCAN_DIV - 1));
  assign wrap = tick && (idx_q == DIG_HUNDREDS);

  // Dwell prescaler and digit index; an invalid index falls back to units.
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (idx_q == DIG_INVALID) begin
      idx_d = DIG_UNITS;
    end else if (tick) begin
      case (idx_q)
        DIG_UNITS: idx_d = DIG_TENS;
        DIG_TENS:  idx_d = DIG_HUNDREDS;
        default:   idx_d = DIG_UNITS;
      endcase
    end
  end

  // Capture into shadow; promote to active at scan wrap, same-cycle load taking priority.
  always_comb begin
    shadow_d = load ? bcd_in : shadow_q;
    active_d = wrap ? shadow_d : active_q;
  end

  // Pick the nibble for the current digit and decide leading-zero blanking.
  always_comb begin
    digitNibble = 4'd0;
    digitBlank  = 1'b1;
    case (idx_q)
      DIG_UNITS: begin
        digitNibble = active_q[3:0];
        digitBlank  = 1'b0;
      end
      DIG_TENS: begin
        digitNibble = active_q[7:4];
        digitBlank  = (BLANK_LZ != 0) && (active_q[11:4] == 8'h00);
      end
      DIG_HUNDREDS: begin
        digitNibble = active_q[11:8];
        digitBlank  = (BLANK_LZ != 0) && (active_q[11:8] == 4'h0);
      end
      default: begin
        digitNibble = 4'd0;
        digitBlank  = 1'b1;
      end
    endcase
  end

  bcd_to_seg u_decode (
    .nibble_i (digitNibble),
    .blank_i  (digitBlank),
    .seg_o    (seg_d)
  );

  // Digit enable for the current index; an out-of-range index enables nothing.
  always_comb begin
    sel_d = ~(3'b001 << idx_q);
  end

  // State and registered outputs; reset darkens the display immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      idx_q    <= DIG_UNITS;
      shadow_q <= 12'h000;
      active_q <= 12'h000;
      sel_q    <= SEL_OFF;
      seg_q    <= SEG_BLANK;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      sel_q    <= sel_d;
      seg_q    <= seg_d;
    end
  end

  assign sel = sel_q;
  assign seg = seg_q;

endmodule
